// File: rtl/ps2_host_tx_if.sv
// Bundle between the system-side command port, the PS/2 pad levels and ps2_host_tx.
// The master side supplies the command and the pin levels; the slave (the transmitter) drives the rest.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output tx_data, tx_start, ps2_clk, ps2_data,
    input  ps2_clk_oe, ps2_data_oe, busy, done, error
  );

  modport slave (
    input  tx_data, tx_start, ps2_clk, ps2_data,
    output ps2_clk_oe, ps2_data_oe, busy, done, error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit/request, serialisation on device clock
// falling edges, odd parity, device ACK check and start/transfer timeouts.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES       = 2500,
  parameter int START_TIMEOUT_CYCLES = 375000,
  parameter int XFER_TIMEOUT_CYCLES  = 50000
) (
  input  logic clk,
  input  logic reset_n,
  inout  wire  VPWR,
  inout  wire  VGND,
  ps2_host_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_WAIT_CLK, S_SHIFT, S_ACK_WAIT, S_RELEASE, S_FAIL
  } state_e;

  localparam logic [18:0] INHIBIT_LAST = 19'(INHIBIT_CYCLES - 1);
  localparam logic [18:0] START_LAST   = 19'(START_TIMEOUT_CYCLES - 1);
  localparam logic [18:0] XFER_LAST    = 19'(XFER_TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [9:0]  shift_q;
  logic [3:0]  bit_cnt_q;
  logic [18:0] tmo_q;
  logic [18:0] tmo_d;
  logic        clk_oe_q, data_oe_q, busy_q, done_q, error_q;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic data_s1_q, data_s2_q;
  logic clk_fall, in_xfer, fail_req;

  logic unused_rails;
  assign unused_rails = VPWR ^ VGND;

  // NOTE: synchronisers reset to 1 (idle bus level) so no false edge follows reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= bus.ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= bus.ps2_data;
      data_s2_q  <= data_s1_q;
    end
  end

  assign clk_fall = clk_prev_q & ~clk_s2_q;
  assign tmo_d    = tmo_q + 19'd1;
  assign in_xfer  = state_q inside {S_SHIFT, S_ACK_WAIT, S_RELEASE};

  // Start timeout, transfer timeout and NACK all funnel into the one failure exit.
  assign fail_req = (state_q == S_WAIT_CLK && !clk_fall && tmo_q == START_LAST)
                  || (in_xfer && tmo_q == XFER_LAST)
                  || (state_q == S_ACK_WAIT && clk_fall && data_s2_q);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '1;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (fail_req) begin
        state_q   <= S_FAIL;
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        busy_q    <= 1'b0;
        done_q    <= 1'b1;
        error_q   <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            // A start coinciding with the done pulse is dropped.
            if (bus.tx_start && !done_q) begin
              shift_q   <= {1'b1, ~^bus.tx_data, bus.tx_data};
              bit_cnt_q <= '0;
              tmo_q     <= '0;
              clk_oe_q  <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (tmo_q == INHIBIT_LAST) begin
              data_oe_q <= 1'b1;
              state_q   <= S_REQ;
            end else begin
              tmo_q <= tmo_d;
            end
          end
          S_REQ: begin
            clk_oe_q <= 1'b0;
            tmo_q    <= '0;
            state_q  <= S_WAIT_CLK;
          end
          S_WAIT_CLK: begin
            if (clk_fall) begin
              data_oe_q <= ~shift_q[0];
              shift_q   <= {1'b1, shift_q[9:1]};
              bit_cnt_q <= 4'd1;
              tmo_q     <= '0;
              state_q   <= S_SHIFT;
            end else begin
              tmo_q <= tmo_d;
            end
          end
          S_SHIFT: begin
            tmo_q <= tmo_d;
            if (clk_fall) begin
              data_oe_q <= ~shift_q[0];
              shift_q   <= {1'b1, shift_q[9:1]};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd9) state_q <= S_ACK_WAIT;
            end
          end
          S_ACK_WAIT: begin
            tmo_q <= tmo_d;
            if (clk_fall) state_q <= S_RELEASE;
          end
          S_RELEASE: begin
            tmo_q <= tmo_d;
            if (clk_s2_q && data_s2_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          S_FAIL:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.ps2_clk_oe  = clk_oe_q;
  assign bus.ps2_data_oe = data_oe_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte (LED set, typematic rate, reset, …) from the system to the attached keyboard over the shared open-drain PS/2 clock and data lines. It is the transmit counterpart of the PS/2 receive decoder; its `busy` output gates that decoder while a transfer is in progress. The device supplies the bit clock. The block handles the inhibit/request sequence, bit serialisation on device clock edges, odd parity, the device ACK, and protocol timeouts.

## Interface
Parameters:
- `INHIBIT_CYCLES`, 2500: cycles the clock line is held low before the request (100 µs at 25 MHz).
- `START_TIMEOUT_CYCLES`, 375000: maximum cycles from clock release to the first device falling edge (15 ms).
- `XFER_TIMEOUT_CYCLES`, 50000: maximum cycles from the first device falling edge to the end of the ACK (2 ms).

Ports:
- `clk` input 1: system clock, 25 MHz.
- `reset_n` input 1: one clock; reset is asynchronous and active-low.
- `VPWR` inout 1: power rail; no logic.
- `VGND` inout 1: ground rail; no logic.
- `tx_data` input 8: byte to send; sampled on the accepted `tx_start`.
- `tx_start` input 1: request strobe; ignored while `busy`=1.
- `ps2_clk` input 1: PS/2 clock pin level (asynchronous).
- `ps2_data` input 1: PS/2 data pin level (asynchronous).
- `ps2_clk_oe` output 1: 1 pulls the clock line low; 0 releases it. The pad output value is tied to 0.
- `ps2_data_oe` output 1: 1 pulls the data line low; 0 releases it.
- `busy` output 1: transfer in progress.
- `done` output 1: one-cycle pulse at transfer end (success or failure).
- `error` output 1: valid only with `done`; 1 means NACK or timeout.

## Operation
- Both pin inputs pass through 2-FF synchronisers. A falling edge is detected when the previous synchronised clock is 1 and the current one is 0.
- The frame shift register holds 10 bits, LSB-first: `{1 (stop), ~^tx_data (odd parity), tx_data}`. It is loaded at accept. A 4-bit bit counter and a 19-bit timeout counter are used. Parameters must be ≤ 2^19−1.
- FSM states and transitions:
  - IDLE: both oe = 0, `busy` = 0. `tx_start` loads the frame, clears the counters and moves to INHIBIT.
  - INHIBIT: `ps2_clk_oe` = 1, `ps2_data_oe` = 0 for exactly INHIBIT_CYCLES cycles, then REQ.
  - REQ: one cycle with `ps2_clk_oe` = 1 and `ps2_data_oe` = 1 (start bit), then WAIT_CLK.
  - WAIT_CLK: `ps2_clk_oe` = 0, `ps2_data_oe` = 1. The timeout counter runs.
    - On the first falling edge: drive bit 0 (`ps2_data_oe` = ~bit), clear the timeout counter and move to SHIFT.
    - When the counter reaches START_TIMEOUT_CYCLES: FAIL.
  - SHIFT: on each falling edge, present the next frame bit. The 10th falling edge presents stop (`ps2_data_oe` = 0) and moves to ACK_WAIT.
  - ACK_WAIT: on the 11th falling edge, sample synchronised `ps2_data`. A value of 0 means ACK and moves to RELEASE. A value of 1 means NACK and moves to FAIL.
  - RELEASE: wait for synchronised `ps2_clk` and `ps2_data` both = 1, then pulse `done` with `error` = 0 and return to IDLE.
- The XFER_TIMEOUT_CYCLES counter runs in SHIFT, ACK_WAIT and RELEASE. On expiry: FAIL.
- FAIL: both oe = 0, `done` = 1, `error` = 1 for one cycle, then IDLE.
- `tx_start` asserted during `busy` is dropped, not queued. `tx_start` in the same cycle that `done` pulses is also dropped.

## Timing
- Reset values: `ps2_clk_oe` = 0, `ps2_data_oe` = 0, `busy` = 0, `done` = 0, `error` = 0. State is IDLE and the synchronisers reset to 1.
- Reset mid-transfer releases both lines immediately (asynchronously).
- `busy` rises and `ps2_clk_oe` rises on the clock edge after the accepted `tx_start`.
- `busy` falls on the same edge on which `done` rises.
- From a pin falling edge to the `ps2_data_oe` update is 3 clk cycles: 2 synchroniser stages plus the edge register.
- ACK sampling has the same 3-cycle delay.
- All outputs are registered.

## Test plan
- Send 0xED with the device model at 12.5 kHz:
  - `ps2_clk_oe` is high for 2500 cycles, then `ps2_data_oe` rises one cycle before the clock is released.
  - The device captures bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - The model ACKs → `done`=1, `error`=0; `busy` is high for the whole transfer.
- Send 0x01 → parity bit 0. Send 0x00 → parity bit 1. Both end with `done`, `error`=0.
- Device leaves data high on the 11th clock → FAIL: `done`=1, `error`=1, both oe = 0.
- Device never clocks (START_TIMEOUT_CYCLES=1000 in sim) → `done`/`error` pulse exactly 1000 cycles after clock release.
- Device stops after 4 clocks (XFER_TIMEOUT_CYCLES=2000 in sim) → `error` pulse 2000 cycles after the first falling edge.
- Second `tx_start` during SHIFT is ignored, and the frame stays unchanged.
- Assert `reset_n` low mid-SHIFT → both oe = 0 and `busy` = 0 without waiting for a `clk` edge.
- After reset is released, a new 0xF4 send completes normally.
